// File: rtl/dmni_br_arbiter_if.sv
// rtl/dmni_br_arbiter_if.sv - BrNoC local injection port (req/ack handshake plus 36-bit packet)
interface dmni_br_arbiter_if #(
  parameter int DATA_W = 36
) ();
  logic              br_req_o;
  logic [DATA_W-1:0] br_data_o;
  logic              br_ack_i;

  modport master (output br_req_o, output br_data_o, input br_ack_i);
  modport slave  (input br_req_o, input br_data_o, output br_ack_i);
endinterface

// File: rtl/dmni_br_arbiter.sv
// rtl/dmni_br_arbiter.sv - software/monitor round-robin arbiter onto the BrNoC local port
// Optional ack timeout enabled by defining BR_TIMEOUT_EN.
module dmni_br_arbiter #(
  parameter int         PAYLOAD_W   = 16,
  parameter int         SEQ_W       = 8,
  parameter logic [3:0] MON_KSVC    = 4'h4,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [15:0]           address_i,
  input  logic                  sw_req_i,
  input  logic [3:0]            sw_ksvc_i,
  input  logic [PAYLOAD_W-1:0]  sw_payload_i,
  output logic                  sw_busy_o,
  output logic                  sw_done_o,
  input  logic                  mon_req_i,
  input  logic [PAYLOAD_W-1:0]  mon_payload_i,
  output logic                  mon_ack_o,
  output logic                  err_o,
  dmni_br_arbiter_if.master     br
);

  localparam int   DATA_W  = PAYLOAD_W + 20;
  localparam logic SRC_SW  = 1'b0;
  localparam logic SRC_MON = 1'b1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               src_q, src_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic               err_q, err_d;
  logic               pick_mon;

  // Address bits above the source field are displaced by the sequence number.
  logic unused_addr;
  assign unused_addr = ^address_i[15:16-SEQ_W];

`ifdef BR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    src_d    = src_q;
    data_d   = data_q;
    seq_d    = seq_q;
    err_d    = err_q;
    pick_mon = 1'b0;
`ifdef BR_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (sw_req_i || mon_req_i) begin
          pick_mon = mon_req_i && (!sw_req_i || (last_q == SRC_SW));
          src_d    = pick_mon;
          last_d   = pick_mon;
          data_d   = {(pick_mon ? mon_payload_i : sw_payload_i), seq_q,
                      address_i[15-SEQ_W:0], (pick_mon ? MON_KSVC : sw_ksvc_i)};
          err_d    = 1'b0;
          state_d  = SEND;
`ifdef BR_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      SEND: begin
        if (br.br_ack_i) begin
          seq_d   = seq_q + 1'b1;
          state_d = DONE;
        end
`ifdef BR_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      last_q  <= SRC_MON;
      src_q   <= SRC_SW;
      data_q  <= '0;
      seq_q   <= '0;
      err_q   <= 1'b0;
`ifdef BR_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      src_q   <= src_d;
      data_q  <= data_d;
      seq_q   <= seq_d;
      err_q   <= err_d;
`ifdef BR_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign br.br_req_o  = (state_q == SEND);
  assign br.br_data_o = data_q;
  assign sw_busy_o    = (state_q != IDLE) && (src_q == SRC_SW);
  assign sw_done_o    = (state_q == DONE) && (src_q == SRC_SW);
  assign mon_ack_o    = (state_q == DONE) && (src_q == SRC_MON);
`ifdef BR_TIMEOUT_EN
  assign err_o        = (state_q == DONE) && err_q;
`else
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_dmni_br_arbiter.sv
// tb/tb_dmni_br_arbiter.sv - directed bench for dmni_br_arbiter
module tb_dmni_br_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] address;
  logic        sw_req, mon_req;
  logic [3:0]  sw_ksvc;
  logic [15:0] sw_payload, mon_payload;
  logic        sw_busy, sw_done, mon_ack, err;
  int          checks = 0;
  int          errors = 0;

  dmni_br_arbiter_if #(.DATA_W(36)) br_if ();

  dmni_br_arbiter #(.TIMEOUT_CYC(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .address_i(address),
    .sw_req_i(sw_req), .sw_ksvc_i(sw_ksvc), .sw_payload_i(sw_payload),
    .sw_busy_o(sw_busy), .sw_done_o(sw_done),
    .mon_req_i(mon_req), .mon_payload_i(mon_payload), .mon_ack_o(mon_ack),
    .err_o(err), .br(br_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] pkt(input logic [15:0] p, input logic [7:0] s, input logic [3:0] k);
    return {p, s, 8'h02, k};
  endfunction

  initial begin
    address = 16'h0102; sw_req = 0; mon_req = 0; sw_ksvc = 0;
    sw_payload = 0; mon_payload = 0; br_if.br_ack_i = 0;
    #12;
    check("rst_req",  36'(br_if.br_req_o), 36'd0);
    check("rst_data", br_if.br_data_o, 36'd0);
    check("rst_outs", 36'({sw_busy, sw_done, mon_ack, err}), 36'd0);
    rst_n = 1;
    tick();

    // single software packet, ack after 2 cycles
    sw_req = 1; sw_ksvc = 4'h3; sw_payload = 16'hBEEF;
    tick();
    check("sw_req",  36'(br_if.br_req_o), 36'd1);
    check("sw_data", br_if.br_data_o, {16'hBEEF, 16'h0002, 4'h3});
    check("sw_busy", 36'(sw_busy), 36'd1);
    tick();
    check("sw_hold", 36'(br_if.br_req_o), 36'd1);
    br_if.br_ack_i = 1;
    tick();
    check("sw_done", 36'({br_if.br_req_o, sw_done, mon_ack, err}), 36'b0100);
    sw_req = 0; br_if.br_ack_i = 0;
    tick();
    check("sw_idle", 36'({br_if.br_req_o, sw_done, sw_busy}), 36'd0);

    // monitor only
    mon_req = 1; mon_payload = 16'h1234;
    tick();
    check("mon_data", br_if.br_data_o, pkt(16'h1234, 8'd1, 4'h4));
    check("mon_busy", 36'(sw_busy), 36'd0);
    br_if.br_ack_i = 1;
    tick();
    check("mon_ack", 36'({sw_done, mon_ack, err}), 36'b010);
    mon_req = 0; br_if.br_ack_i = 0;
    tick();

    // contention with ack held high: last grant was MON, so SW leads
    sw_req = 1; mon_req = 1; sw_ksvc = 4'h5; sw_payload = 16'hAAAA; mon_payload = 16'h5555;
    br_if.br_ack_i = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i % 2 == 0)
        check($sformatf("rr_data%0d", i), br_if.br_data_o, pkt(16'hAAAA, 8'(2 + i), 4'h5));
      else
        check($sformatf("rr_data%0d", i), br_if.br_data_o, pkt(16'h5555, 8'(2 + i), 4'h4));
      tick();
      check($sformatf("rr_pulse%0d", i), 36'({sw_done, mon_ack}), (i % 2 == 0) ? 36'b10 : 36'b01);
      tick();
    end
    sw_req = 0; mon_req = 0; br_if.br_ack_i = 0;
    tick();

    // data stability with ack withheld; ksvc 4'h4 forwarded from software
    sw_req = 1; sw_ksvc = 4'h4; sw_payload = 16'h1111;
    tick();
    sw_req = 0;
    for (int i = 0; i < 10; i++) begin
      sw_payload = ~sw_payload; sw_ksvc = 4'(i);
      tick();
      check($sformatf("stable%0d", i), {br_if.br_req_o, br_if.br_data_o[34:0]},
            {1'b1, pkt(16'h1111, 8'd6, 4'h4)} & 36'h7_FFFF_FFFF | 36'h8_0000_0000);
    end
    check("stable_full", br_if.br_data_o, pkt(16'h1111, 8'd6, 4'h4));
    br_if.br_ack_i = 1;
    tick();
    check("stable_done", 36'(sw_done), 36'd1);
    br_if.br_ack_i = 0;
    tick();

    // sequence wrap: seq is 7 now, run 256 packets
    sw_req = 1; sw_ksvc = 4'h1; sw_payload = 16'h0;
    br_if.br_ack_i = 1;
    for (int i = 0; i < 256; i++) begin
      tick();
      check($sformatf("wrap_seq%0d", i), 36'(br_if.br_data_o[19:12]), 36'((7 + i) % 256));
      tick();
      tick();
    end
    sw_req = 0; br_if.br_ack_i = 0;
    tick();

`ifdef BR_TIMEOUT_EN
    // seq is back to 7; no ack -> timeout after 8 SEND cycles
    sw_req = 1; sw_ksvc = 4'h2; sw_payload = 16'hCAFE;
    tick();
    sw_req = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("to_req%0d", i), 36'(br_if.br_req_o), 36'd1);
    end
    tick();
    check("to_done", 36'({br_if.br_req_o, sw_done, err}), 36'b011);
    tick();
    check("to_idle", 36'({sw_done, err}), 36'd0);
    sw_req = 1; br_if.br_ack_i = 1;
    tick();
    check("to_seq", 36'(br_if.br_data_o[19:12]), 36'd7);
    tick();
    sw_req = 0; br_if.br_ack_i = 0;
    tick();
`endif

    // async reset mid-SEND
    sw_req = 1; sw_ksvc = 4'h9; sw_payload = 16'h7777;
    tick();
    check("rs_send", 36'(br_if.br_req_o), 36'd1);
    #2 rst_n = 0;
    #1;
    check("rs_async", 36'(br_if.br_req_o), 36'd0);
    sw_req = 0;
    tick();
    check("rs_nodone", 36'({sw_done, mon_ack, sw_busy}), 36'd0);
    rst_n = 1;
    sw_req = 1; sw_ksvc = 4'h3; sw_payload = 16'hBEEF;
    tick();
    check("rs_seq0", br_if.br_data_o, {16'hBEEF, 16'h0002, 4'h3});
    sw_req = 0; br_if.br_ack_i = 1;
    tick();
    check("rs_done", 36'(sw_done), 36'd1);
    br_if.br_ack_i = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
